// File: rtl/usbdev_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usbdev_pkg                                                   |
// | Description : Shared types for the usbdev line front end: decoded line     |
// |               state encoding, the line-monitor FSM states and the pin      |
// |               decode helper.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package usbdev_pkg;

   typedef enum logic [1:0] {
      LsSe0 = 2'd0,
      LsJ   = 2'd1,
      LsK   = 2'd2,
      LsSe1 = 2'd3
   } line_state_e;

   typedef enum logic [1:0] {
      LmBusy  = 2'd0,
      LmSe0   = 2'd1,
      LmJWait = 2'd2
   } lm_state_e;

   // Full-speed J is D+ high. A flipped connector swaps only the differential
   // states; SE0/SE1 are symmetric and unaffected.
   function automatic line_state_e decode_line(input logic dp, input logic dn,
                                               input logic flip);
      line_state_e ls;
      case ({dp, dn})
         2'b00:   ls = LsSe0;
         2'b10:   ls = flip ? LsK : LsJ;
         2'b01:   ls = flip ? LsJ : LsK;
         default: ls = LsSe1;
      endcase
      return ls;
   endfunction

endpackage : usbdev_pkg
`default_nettype wire

// File: rtl/prim_flop_2sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prim_flop_2sync                                              |
// | Description : Two-stage flop synchronizer with asynchronous active-low     |
// |               reset.                                                       |
// |   clk_i  : destination clock                                               |
// |   rst_ni : asynchronous active-low reset                                   |
// |   d_i    : asynchronous input                                              |
// |   q_o    : synchronized output (2 cycles latency)                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prim_flop_2sync #(
   parameter int unsigned          Width      = 16,
   parameter logic [Width-1:0]     ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] r_stage1;
   logic [Width-1:0] r_stage2;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stage1 <= ResetValue;
         r_stage2 <= ResetValue;
      end else begin
         r_stage1 <= d_i;
         r_stage2 <= r_stage1;
      end
   end

   assign q_o = r_stage2;

endmodule : prim_flop_2sync
`default_nettype wire

// File: rtl/usbdev_us_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usbdev_us_tick_gen                                           |
// | Description : Divides clk_48mhz_i by TickDiv to give a 1 us strobe.        |
// |   clk_48mhz_i : 48 MHz clock                                               |
// |   rst_ni      : asynchronous active-low reset                              |
// |   tick_en_i   : advance the divider; low freezes it and masks the tick     |
// |   us_tick_o   : 1-cycle pulse on every TickDiv-th enabled cycle            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module usbdev_us_tick_gen #(
   parameter int unsigned TickDiv = 48
) (
   input  logic clk_48mhz_i,
   input  logic rst_ni,
   input  logic tick_en_i,
   output logic us_tick_o
);

   localparam logic [7:0] c_last = 8'(TickDiv - 1);

   logic [7:0] r_cnt;
   logic       w_wrap;

   // The pulse is taken straight from the counter so that dropping the
   // enable masks it in the same cycle.
   assign w_wrap = tick_en_i && (r_cnt == c_last);

   always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= 8'd0;
      end else if (w_wrap) begin
         r_cnt <= 8'd0;
      end else if (tick_en_i) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign us_tick_o = w_wrap;

endmodule : usbdev_us_tick_gen
`default_nettype wire

// File: rtl/usbdev_line_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usbdev_line_monitor                                          |
// | Description : Line front end of the link-state detector. Generates the     |
// |               1 us tick, decodes D+/D- into line states and derives J,     |
// |               idle, EOP and SE1 indications.                               |
// |   clk_48mhz_i   : 48 MHz clock                                             |
// |   rst_ni        : asynchronous active-low reset                            |
// |   tick_en_i     : enables the us tick divider                              |
// |   usb_dp_i/dn_i : raw D+/D- receive pins                                   |
// |   usb_oe_i      : device is driving the bus (blanks all detection)         |
// |   pinflip_i     : swap D+/D- interpretation                                |
// |   us_tick_o     : 1 us strobe                                              |
// |   line_state_o  : decoded line (SE0/J/K/SE1)                               |
// |   rx_j_det_o    : J held >= JCycles                                        |
// |   rx_idle_det_o : J held >= IdleCycles                                     |
// |   eop_o         : pulse, valid full-speed EOP completed                    |
// |   se1_err_o     : pulse, entry into SE1                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module usbdev_line_monitor
   import usbdev_pkg::*;
#(
   parameter int unsigned TickDiv    = 48,
   parameter bit          SyncOn     = 1'b1,
   parameter int unsigned JCycles    = 4,
   parameter int unsigned IdleCycles = 28,
   parameter int unsigned EopMin     = 4,
   parameter int unsigned EopMax     = 12
) (
   input  logic       clk_48mhz_i,
   input  logic       rst_ni,
   input  logic       tick_en_i,
   input  logic       usb_dp_i,
   input  logic       usb_dn_i,
   input  logic       usb_oe_i,
   input  logic       pinflip_i,
   output logic       us_tick_o,
   output logic [1:0] line_state_o,
   output logic       rx_j_det_o,
   output logic       rx_idle_det_o,
   output logic       eop_o,
   output logic       se1_err_o
);

   localparam int unsigned c_jw = $clog2(IdleCycles + 1);
   localparam int unsigned c_sw = $clog2(EopMax + 2);

   localparam logic [c_jw-1:0] c_j_thr   = c_jw'(JCycles);
   localparam logic [c_jw-1:0] c_j_max   = c_jw'(IdleCycles);
   localparam logic [c_sw-1:0] c_se0_one = c_sw'(1);
   localparam logic [c_sw-1:0] c_se0_sat = c_sw'(EopMax + 1);
   localparam logic [c_sw-1:0] c_eop_min = c_sw'(EopMin);
   localparam logic [c_sw-1:0] c_eop_max = c_sw'(EopMax);

   // ---------------------------------------------------------------- tick
   usbdev_us_tick_gen #(
      .TickDiv (TickDiv)
   ) u_tick (
      .clk_48mhz_i (clk_48mhz_i),
      .rst_ni      (rst_ni),
      .tick_en_i   (tick_en_i),
      .us_tick_o   (us_tick_o)
   );

   // ------------------------------------------------------------ pin path
   logic [1:0] w_pins;   // {dp, dn}

   generate
      if (SyncOn) begin : g_sync
         prim_flop_2sync #(
            .Width      (2),
            .ResetValue (2'b00)
         ) u_sync (
            .clk_i  (clk_48mhz_i),
            .rst_ni (rst_ni),
            .d_i    ({usb_dp_i, usb_dn_i}),
            .q_o    (w_pins)
         );
      end else begin : g_nosync
         assign w_pins = {usb_dp_i, usb_dn_i};
      end
   endgenerate

   line_state_e w_line_d;
   line_state_e r_line;
   logic        r_se1_err;

   assign w_line_d = decode_line(w_pins[1], w_pins[0], pinflip_i);

   // The SE1 edge is detected against the registered line so that the pulse
   // lines up with line_state_o first showing SE1.
   always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_line    <= LsSe0;
         r_se1_err <= 1'b0;
      end else begin
         r_line    <= w_line_d;
         r_se1_err <= !usb_oe_i && (w_line_d == LsSe1) && (r_line != LsSe1);
      end
   end

   // ----------------------------------------------------------- J counter
   logic [c_jw-1:0] r_jcnt;
   logic [c_jw-1:0] w_jcnt_d;
   logic            r_j_det;
   logic            r_idle_det;

   always_comb begin
      w_jcnt_d = r_jcnt;
      if (usb_oe_i || (r_line != LsJ)) begin
         w_jcnt_d = '0;
      end else if (r_jcnt != c_j_max) begin
         w_jcnt_d = r_jcnt + c_jw'(1);
      end
   end

   // Detect flags are registered from the next count so they rise together
   // with the count reaching the threshold rather than a cycle later.
   always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_jcnt     <= '0;
         r_j_det    <= 1'b0;
         r_idle_det <= 1'b0;
      end else begin
         r_jcnt     <= w_jcnt_d;
         r_j_det    <= (w_jcnt_d >= c_j_thr);
         r_idle_det <= (w_jcnt_d == c_j_max);
      end
   end

   // ----------------------------------------------------------------- FSM
   lm_state_e       r_state;
   lm_state_e       w_state_d;
   logic [c_sw-1:0] r_se0_cnt;
   logic [c_sw-1:0] w_se0_cnt_d;
   logic            w_eop_d;
   logic            r_eop;

   always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= LmBusy;
         r_se0_cnt <= '0;
         r_eop     <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_se0_cnt <= w_se0_cnt_d;
         r_eop     <= w_eop_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_se0_cnt_d = r_se0_cnt;
      w_eop_d     = 1'b0;
      if (usb_oe_i) begin
         // Our own transmission must never be mistaken for received EOPs.
         w_state_d = LmBusy;
      end else begin
         case (r_state)
            LmBusy: begin
               if (r_line == LsSe0) begin
                  w_state_d   = LmSe0;
                  w_se0_cnt_d = c_se0_one;
               end
            end
            LmSe0: begin
               case (r_line)
                  LsSe0: begin
                     if (r_se0_cnt != c_se0_sat) begin
                        w_se0_cnt_d = r_se0_cnt + c_sw'(1);
                     end
                  end
                  LsJ: begin
                     // Out-of-window SE0 (bus reset, low-speed EOP) still
                     // ends in J-wait, just without a pulse.
                     w_state_d = LmJWait;
                     w_eop_d   = (r_se0_cnt >= c_eop_min) &&
                                 (r_se0_cnt <= c_eop_max);
                  end
                  default: w_state_d = LmBusy;
               endcase
            end
            LmJWait: begin
               if (r_line == LsSe0) begin
                  w_state_d   = LmSe0;
                  w_se0_cnt_d = c_se0_one;
               end else if (r_line != LsJ) begin
                  w_state_d = LmBusy;
               end
            end
            default: w_state_d = LmBusy;
         endcase
      end
   end

   // ------------------------------------------------------------- outputs
   assign line_state_o  = r_line;
   assign rx_j_det_o    = r_j_det;
   assign rx_idle_det_o = r_idle_det;
   assign eop_o         = r_eop;
   assign se1_err_o     = r_se1_err;

endmodule : usbdev_line_monitor
`default_nettype wire

// File: tb/tb_usbdev_line_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_usbdev_line_monitor                                       |
// | Description : Self-checking bench for usbdev_line_monitor. A cycle-level   |
// |               reference built from line run lengths predicts every         |
// |               output each cycle; directed phases plus random line segments.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_usbdev_line_monitor;

   localparam int unsigned TickDiv    = 48;
   localparam int unsigned JCycles    = 4;
   localparam int unsigned IdleCycles = 28;
   localparam int unsigned EopMin     = 4;
   localparam int unsigned EopMax     = 12;

   localparam logic [1:0] c_pin_se0 = 2'b00;
   localparam logic [1:0] c_pin_j   = 2'b10;   // {dp, dn}, unflipped
   localparam logic [1:0] c_pin_k   = 2'b01;
   localparam logic [1:0] c_pin_se1 = 2'b11;

   logic       r_clk = 1'b0;
   logic       r_rst_n;
   logic       r_en, r_dp, r_dn, r_oe, r_flip;
   logic       w_tick, w_jdet, w_idle, w_eop, w_se1;
   logic [1:0] w_line;

   always #5 r_clk = ~r_clk;

   usbdev_line_monitor #(
      .TickDiv    (TickDiv),
      .SyncOn     (1'b1),
      .JCycles    (JCycles),
      .IdleCycles (IdleCycles),
      .EopMin     (EopMin),
      .EopMax     (EopMax)
   ) dut (
      .clk_48mhz_i   (r_clk),
      .rst_ni        (r_rst_n),
      .tick_en_i     (r_en),
      .usb_dp_i      (r_dp),
      .usb_dn_i      (r_dn),
      .usb_oe_i      (r_oe),
      .pinflip_i     (r_flip),
      .us_tick_o     (w_tick),
      .line_state_o  (w_line),
      .rx_j_det_o    (w_jdet),
      .rx_idle_det_o (w_idle),
      .eop_o         (w_eop),
      .se1_err_o     (w_se1)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   logic [1:0] m_pq[$];        // pins seen at the last two edges
   logic [1:0] m_line;
   int         m_en_done, m_jrun, m_se0run;
   logic       e_tick, e_jdet, e_idle, e_eop, e_se1;
   int         n_eop_seen, n_se1_seen, n_tick_seen;

   function automatic logic [1:0] ref_decode(input logic [1:0] pins,
                                             input logic flip);
      if (pins == 2'b00) return 2'd0;
      if (pins == 2'b11) return 2'd3;
      return (pins[1] ^ flip) ? 2'd1 : 2'd2;
   endfunction

   task automatic model_reset();
      m_pq      = '{2'b00, 2'b00};
      m_line    = 2'd0;
      m_en_done = 0;
      m_jrun    = 0;
      m_se0run  = 0;
      e_tick = 1'b0; e_jdet = 1'b0; e_idle = 1'b0; e_eop = 1'b0; e_se1 = 1'b0;
   endtask

   // One clock edge: line is the pin value from two edges ago; J and SE0
   // behaviour follows from run lengths of the line seen before this edge.
   task automatic model_edge();
      logic [1:0] prev;
      prev = m_line;
      if (r_en) m_en_done++;
      e_tick = r_en && (((m_en_done + 1) % TickDiv) == 0);

      m_pq.push_back({r_dp, r_dn});
      m_line = ref_decode(m_pq[0], r_flip);
      void'(m_pq.pop_front());

      e_se1 = !r_oe && (m_line == 2'd3) && (prev != 2'd3);

      if (r_oe || prev != 2'd1) m_jrun = 0;
      else                      m_jrun++;
      e_jdet = (m_jrun >= JCycles);
      e_idle = (m_jrun >= IdleCycles);

      e_eop = 1'b0;
      if (r_oe) begin
         m_se0run = 0;
      end else if (prev == 2'd0) begin
         m_se0run++;
      end else begin
         if (prev == 2'd1) e_eop = (m_se0run >= EopMin) && (m_se0run <= EopMax);
         m_se0run = 0;
      end
   endtask

   task automatic step();
      @(posedge r_clk);
      if (!r_rst_n) model_reset();
      else          model_edge();
      #1;
      check("us_tick",  32'(w_tick), 32'(e_tick));
      check("line",     32'(w_line), 32'(m_line));
      check("j_det",    32'(w_jdet), 32'(e_jdet));
      check("idle_det", 32'(w_idle), 32'(e_idle));
      check("eop",      32'(w_eop),  32'(e_eop));
      check("se1_err",  32'(w_se1),  32'(e_se1));
      if (w_eop)  n_eop_seen++;
      if (w_se1)  n_se1_seen++;
      if (w_tick) n_tick_seen++;
   endtask

   task automatic run(input logic [1:0] pins, input int n);
      {r_dp, r_dn} = pins;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic eop_case(input string tag, input int se0_len, input int exp);
      run(c_pin_k, 20);
      n_eop_seen = 0;
      run(c_pin_se0, se0_len);
      run(c_pin_j, 10);
      check(tag, 32'(n_eop_seen), 32'(exp));
   endtask

   // -------------------------------------------------------------- stimulus
   initial begin
      int unsigned pick;
      int          len;
      logic [1:0]  p;

      r_rst_n = 1'b0; r_en = 1'b1; r_oe = 1'b0; r_flip = 1'b0;
      {r_dp, r_dn} = c_pin_j;
      model_reset();
      for (int i = 0; i < 3; i++) step();
      r_rst_n = 1'b1;

      // Tick cadence and J/idle rise from reset.
      n_tick_seen = 0;
      run(c_pin_j, 200);
      check("tick_count_200", 32'(n_tick_seen), 32'd4);
      r_en = 1'b0;
      run(c_pin_j, 10);
      r_en = 1'b1;
      run(c_pin_j, 60);

      // EOP window boundaries.
      eop_case("eop_se0_8",  8,  1);
      eop_case("eop_se0_3",  3,  0);
      eop_case("eop_se0_13", 13, 0);
      eop_case("eop_se0_4",  4,  1);
      eop_case("eop_se0_12", 12, 1);

      // Drive start coincides with the EOP-terminating J.
      run(c_pin_k, 20);
      n_eop_seen = 0;
      run(c_pin_se0, 8);
      run(c_pin_j, 2);
      r_oe = 1'b1;
      run(c_pin_j, 3);
      r_oe = 1'b0;
      run(c_pin_j, 10);
      check("eop_blanked", 32'(n_eop_seen), 32'd0);

      // Flipped pins: dp=0/dn=1 is J.
      run(c_pin_se0, 5);
      r_flip = 1'b1;
      run(c_pin_se0, 3);
      run(c_pin_k, 40);
      check("flip_idle", 32'(w_idle), 32'd1);
      run(c_pin_se0, 5);
      r_flip = 1'b0;
      run(c_pin_se0, 3);

      // Idle then drive blanking.
      run(c_pin_j, 40);
      r_oe = 1'b1;
      run(c_pin_j, 1);
      check("oe_idle_drop", 32'(w_idle), 32'd0);
      run(c_pin_j, 4);
      r_oe = 1'b0;
      run(c_pin_j, 40);

      // SE1 pulses once.
      run(c_pin_j, 5);
      n_se1_seen = 0;
      run(c_pin_se1, 10);
      check("se1_once", 32'(n_se1_seen), 32'd1);

      // Asynchronous reset in the middle of SE0.
      run(c_pin_se0, 6);
      #2 r_rst_n = 1'b0;
      #1;
      check("arst_line", 32'(w_line), 32'd0);
      check("arst_jdet", 32'(w_jdet), 32'd0);
      check("arst_idle", 32'(w_idle), 32'd0);
      check("arst_eop",  32'(w_eop),  32'd0);
      check("arst_se1",  32'(w_se1),  32'd0);
      check("arst_tick", 32'(w_tick), 32'd0);
      run(c_pin_j, 2);
      r_rst_n = 1'b1;
      run(c_pin_j, 40);

      // Random line segments with occasional drive and tick gating.
      for (int s = 0; s < 300; s++) begin
         pick = $urandom_range(99);
         if (pick < 30)      p = c_pin_se0;
         else if (pick < 70) p = c_pin_j;
         else if (pick < 90) p = c_pin_k;
         else                p = c_pin_se1;
         len  = (p == c_pin_j) ? int'($urandom_range(40, 1))
                               : int'($urandom_range(16, 1));
         r_oe = ($urandom_range(9) == 0);
         r_en = ($urandom_range(9) != 0);
         run(p, len);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_usbdev_line_monitor
`default_nettype wire

// File: doc/usbdev_line_monitor.md
Name: usbdev_line_monitor

Overview:
Upstream front end of the link-state detector. It produces the 1 us tick and decodes the synchronized D+/D- pins into line states. From those it derives the idle, J and end-of-packet indications that the link-state, reset and inactivity logic consume. It sits between the PHY pin interface and usbdev_linkstate in the 48 MHz domain.

Parameters:
TickDiv, 48, clk_48mhz_i cycles per us_tick_o pulse (range 2..255).
SyncOn, 1, 1 inserts 2-flop synchronizers on dp/dn; 0 means inputs are already synchronous.
JCycles, 4, consecutive J cycles before rx_j_det_o asserts (one full-speed bit time).
IdleCycles, 28, consecutive J cycles before rx_idle_det_o asserts (7 bit times).
EopMin, 4, minimum SE0 cycles accepted as a full-speed EOP.
EopMax, 12, maximum SE0 cycles accepted as a full-speed EOP.

Ports:
clk_48mhz_i  in  1  clock
rst_ni  in  1  reset
tick_en_i  in  1  enables the us tick counter
usb_dp_i  in  1  D+ receive pin
usb_dn_i  in  1  D- receive pin
usb_oe_i  in  1  device is driving the bus
pinflip_i  in  1  swap D+/D- interpretation
us_tick_o  out  1  1-cycle pulse every TickDiv cycles
line_state_o  out  2  decoded line: 0 SE0, 1 J, 2 K, 3 SE1
rx_j_det_o  out  1  level: J held for at least JCycles cycles
rx_idle_det_o  out  1  level: J held for at least IdleCycles cycles
eop_o  out  1  pulse: valid full-speed EOP (SE0 then J) completed
se1_err_o  out  1  pulse: entry into SE1

Behaviour:
- Interface: reset is rst_ni, asynchronous, active-low; clock is clk_48mhz_i. All flops reset asynchronously.
- Reset values:
  - us_tick_o = 0, rx_j_det_o = 0, rx_idle_det_o = 0, eop_o = 0, se1_err_o = 0.
  - line_state_o = SE0 (synchronizer flops reset to 0).
  - All counters reset to 0; FSM resets to LmBusy.
- Tick generator:
  - 8-bit counter; increments only when tick_en_i = 1.
  - When counter == TickDiv-1: us_tick_o = 1 for that cycle and the counter wraps to 0.
  - tick_en_i = 0 freezes the counter and forces us_tick_o = 0.
  - The first tick arrives TickDiv cycles after reset release with tick_en_i held high.
- Pin path:
  - SyncOn = 1 adds 2 cycles of latency; the decode register adds 1 more. Pin to line_state_o is 3 cycles (1 cycle when SyncOn = 0).
  - Decode: {dp,dn} = 00 gives SE0, 10 gives J, 01 gives K, 11 gives SE1. When pinflip_i = 1, J and K are swapped.
- Drive blanking:
  - While usb_oe_i = 1, decoding is forced to "busy": J counter held at 0, rx_j_det_o = rx_idle_det_o = 0, FSM forced to LmBusy, eop_o and se1_err_o suppressed.
  - line_state_o still reflects the pins.
- J counter:
  - Counts consecutive decoded-J cycles and saturates at IdleCycles (no wrap).
  - Any non-J cycle clears it to 0.
  - rx_j_det_o = (count >= JCycles); rx_idle_det_o = (count == IdleCycles). Both are registered from the count.
- FSM (states LmBusy, LmSe0, LmJWait):
  - LmBusy, line SE0: go to LmSe0 and load the SE0 counter with 1.
  - LmSe0, line SE0: increment the SE0 counter, saturating at EopMax+1.
  - LmSe0, line J:
    - If EopMin <= count <= EopMax: eop_o = 1 for one cycle, go to LmJWait.
    - Otherwise go to LmJWait with no pulse. Long SE0 is reset or low-speed signalling and is handled downstream.
  - LmSe0, line K or SE1: go to LmBusy with no pulse.
  - LmJWait, line J: stay. Any other line: re-enter LmBusy, or LmSe0 directly if the line is SE0 (count loaded with 1).
- se1_err_o pulses on the cycle line_state_o changes to SE1 from any other state. It does not repeat while SE1 persists.
- Simultaneous events: usb_oe_i rising in the same cycle as an EOP-terminating J suppresses eop_o (blanking wins).

Decomposition:
- usbdev_pkg gains line_state_e (SE0 = 0, J = 1, K = 2, SE1 = 3) and the LmBusy/LmSe0/LmJWait enum.
- Width constants are derived locally with $clog2.
- One sub-module: usbdev_us_tick_gen (TickDiv counter plus enable).
- Synchronizers use prim_flop_2sync.

Test Plan:
- Reset release, tick_en_i = 1 held for 200 cycles: us_tick_o pulses at cycles 48, 96, 144, 192; tick_en_i low for 10 cycles delays the next pulse by exactly 10.
- dp = 1, dn = 0 held from reset (SyncOn = 1): line_state_o = J at cycle 3, rx_j_det_o rises at cycle 7, rx_idle_det_o rises at cycle 31.
- K for 20 cycles, then SE0 for 8, then J: exactly one eop_o pulse; SE0 of 3 or 13 cycles gives no pulse.
- pinflip_i = 1 with dp = 0, dn = 1: line_state_o = J and the idle sequence behaves as in the second scenario.
- J idle established, then usb_oe_i = 1 for 5 cycles: rx_idle_det_o drops the next cycle and re-asserts IdleCycles after usb_oe_i falls.
- Drive dp = dn = 1 for 10 cycles: se1_err_o pulses once; rst_ni asserted mid-SE0 clears all outputs asynchronously.
